fifo_rx: RTL and testbench
==========================

FIFO_RX -- requirements
Module: fifo_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one received frame.
REQ-002 Parameter MAX_FIFO_FRAME, default 16, frame depth; SHALL be a power of two >= 4.
REQ-003 Parameter AFULL_LEVEL, default 12, occupancy at or above which fifo_rx_afull asserts.
REQ-004 clk_fifo_rx  in  1  single clock; all logic on rising edge.
REQ-005 rst_fifo_rx  in  1  reset; synchronous, active-high.
REQ-006 data_in  in  DATA_WIDTH  frame from the receiver shifter.
REQ-007 frame_valid  in  1  one-cycle strobe: data_in and frame_error are valid.
REQ-008 frame_error  in  1  stop-bit/parity error flag of the frame on data_in.
REQ-009 read_frame  in  1  consumer pop request, one frame per asserted cycle.
REQ-010 clear_overrun  in  1  clears the sticky overrun flag.
REQ-011 data_out  out  DATA_WIDTH  popped frame, registered.
REQ-012 data_out_err  out  1  stored frame_error of the popped frame.
REQ-013 data_out_valid  out  1  one-cycle pulse when data_out/data_out_err update.
REQ-014 fifo_rx_full  out  1  occupancy == MAX_FIFO_FRAME.
REQ-015 fifo_rx_empty  out  1  occupancy == 0.
REQ-016 fifo_rx_afull  out  1  occupancy >= AFULL_LEVEL.
REQ-017 fifo_rx_count  out  clog2(MAX_FIFO_FRAME)+1  current occupancy.
REQ-018 overrun  out  1  sticky: a frame was dropped because the FIFO was full.

Function
REQ-019 Storage SHALL be MAX_FIFO_FRAME entries of DATA_WIDTH+1 bits (frame + error bit).
REQ-020 Write and read pointers SHALL be clog2(MAX_FIFO_FRAME) bits and wrap from MAX_FIFO_FRAME-1 to 0.
REQ-021 Write accepted when frame_valid=1 and (not full, or read accepted same cycle); entry stored at write pointer, pointer +1.
REQ-022 Read accepted when read_frame=1 and not empty; entry at read pointer drives data_out/data_out_err on the next edge, data_out_valid=1 that cycle, pointer +1.
REQ-023 Read latency SHALL be exactly one cycle from read_frame sample to data_out_valid.
REQ-024 read_frame while empty SHALL be ignored: no pointer change, data_out held, data_out_valid=0; no write-to-read bypass.
REQ-025 frame_valid while full with no accepted read SHALL drop the frame, leave pointers/count unchanged, set overrun=1.
REQ-026 Simultaneous accepted read and write SHALL leave fifo_rx_count unchanged; when full, the popped entry is output and the new frame stored in its slot.
REQ-027 fifo_rx_count SHALL be +1 on write-only, -1 on read-only, unchanged otherwise; flags SHALL be registered and consistent with count in the same cycle.
REQ-028 data_out/data_out_err SHALL hold last popped value until the next accepted read.
REQ-029 clear_overrun clears overrun next edge; if an overrun event occurs the same cycle, overrun SHALL remain 1.

Reset
REQ-030 With rst_fifo_rx=1 at an edge: pointers=0, fifo_rx_count=0, fifo_rx_empty=1, fifo_rx_full=0, fifo_rx_afull=0, overrun=0, data_out=0, data_out_err=0, data_out_valid=0.
REQ-031 Reset SHALL take priority over frame_valid/read_frame in the same cycle; memory contents need not be cleared.
REQ-032 Reset mid-operation SHALL discard all stored frames; first pop after reset returns only frames written after reset.

Verification
REQ-033 Write 0x41,0x42,0x43 (frame_error 0,1,0), then three reads -> data_out 0x41/0x42/0x43, data_out_err 0/1/0, each one cycle after read_frame, then empty=1.
REQ-034 Write 16 frames 0x00..0x0F -> afull at count 12, full at 16; 17th write 0xAA -> dropped, overrun=1; reads return 0x00..0x0F in order.
REQ-035 Full FIFO, frame_valid=1 and read_frame=1 same cycle with 0x55 -> count stays 16, overrun stays 0, 0x55 read last.
REQ-036 Empty FIFO, read_frame=1 -> data_valid 0, data_out holds; simultaneous read+write 0x77 -> count 1, no data_out_valid.
REQ-037 Overrun set, clear_overrun=1 with dropped write same cycle -> overrun=1; clear_overrun alone -> overrun=0.
REQ-038 Write 5 frames, assert reset with frame_valid=1 -> count 0, empty=1; write 0x99, read -> 0x99.

Source files
------------

// File: rtl/fifo_rx.sv
// Receive-side frame FIFO: buffers frames plus their error flag from the receiver shifter,
// with registered occupancy flags, one-cycle registered pop and a sticky overrun flag.
module fifo_rx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MAX_FIFO_FRAME = 16,
    parameter int unsigned AFULL_LEVEL    = 12
) (
    input  logic                              clk_fifo_rx,
    input  logic                              rst_fifo_rx,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              frame_valid,
    input  logic                              frame_error,
    input  logic                              read_frame,
    input  logic                              clear_overrun,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              data_out_err,
    output logic                              data_out_valid,
    output logic                              fifo_rx_full,
    output logic                              fifo_rx_empty,
    output logic                              fifo_rx_afull,
    output logic [$clog2(MAX_FIFO_FRAME):0]   fifo_rx_count,
    output logic                              overrun
);

    localparam int unsigned AW = $clog2(MAX_FIFO_FRAME);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_FIFO_FRAME);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    // Each entry carries the frame's error bit in the MSB.
    logic [DATA_WIDTH:0] mem [MAX_FIFO_FRAME];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                rd_acc;
    logic                wr_acc;
    logic                drop;
    logic [CW-1:0]       count_d;

    always_comb begin
        rd_acc  = read_frame && !fifo_rx_empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        wr_acc  = frame_valid && (!fifo_rx_full || rd_acc);
        drop    = frame_valid && fifo_rx_full && !rd_acc;
        count_d = fifo_rx_count;
        if (wr_acc && !rd_acc) begin
            count_d = fifo_rx_count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = fifo_rx_count - CW'(1);
        end
    end

    always_ff @(posedge clk_fifo_rx) begin
        if (!rst_fifo_rx && wr_acc) begin
            mem[wr_ptr] <= {frame_error, data_in};
        end
    end

    always_ff @(posedge clk_fifo_rx) begin
        if (rst_fifo_rx) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_rx_count  <= '0;
            fifo_rx_empty  <= 1'b1;
            fifo_rx_full   <= 1'b0;
            fifo_rx_afull  <= 1'b0;
            overrun        <= 1'b0;
            data_out       <= '0;
            data_out_err   <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= rd_acc;
            if (rd_acc) begin
                data_out     <= mem[rd_ptr][DATA_WIDTH-1:0];
                data_out_err <= mem[rd_ptr][DATA_WIDTH];
                rd_ptr       <= rd_ptr + AW'(1);
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            fifo_rx_count <= count_d;
            fifo_rx_empty <= (count_d == '0);
            fifo_rx_full  <= (count_d == FULL_CNT);
            fifo_rx_afull <= (count_d >= AFULL_CNT);
            // A drop in the same cycle wins over a clear request.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rx.sv
// Self-checking bench for fifo_rx: a reference queue model feeds an output scoreboard that a
// monitor drains as frames pop; each scenario task checks flags and occupancy inline.
module tb_fifo_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       frame_valid;
    logic       frame_error;
    logic       read_frame;
    logic       clear_overrun;
    logic [7:0] data_out;
    logic       data_out_err;
    logic       data_out_valid;
    logic       fifo_rx_full;
    logic       fifo_rx_empty;
    logic       fifo_rx_afull;
    logic [4:0] fifo_rx_count;
    logic       overrun;

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;

    logic [8:0] model [$];
    logic [8:0] exp_q [$];
    logic       ovr_m;
    logic [8:0] last_m;

    always #5 clk = ~clk;

    fifo_rx dut (
        .clk_fifo_rx   (clk),
        .rst_fifo_rx   (rst),
        .data_in       (data_in),
        .frame_valid   (frame_valid),
        .frame_error   (frame_error),
        .read_frame    (read_frame),
        .clear_overrun (clear_overrun),
        .data_out      (data_out),
        .data_out_err  (data_out_err),
        .data_out_valid(data_out_valid),
        .fifo_rx_full  (fifo_rx_full),
        .fifo_rx_empty (fifo_rx_empty),
        .fifo_rx_afull (fifo_rx_afull),
        .fifo_rx_count (fifo_rx_count),
        .overrun       (overrun)
    );

    // Expectations are queued before an edge and must appear exactly at that edge.
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (mon_en) begin
            total++;
            if (data_out_valid !== (exp_q.size() > 0)) begin
                $display("FAIL data_out_valid: got %b want %b", data_out_valid, exp_q.size() > 0);
            end else begin
                passed++;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (data_out_valid === 1'b1) begin
                    total++;
                    if ({data_out_err, data_out} !== e) begin
                        $display("FAIL pop_data: got err=%b data=%h want err=%b data=%h",
                                 data_out_err, data_out, e[8], e[7:0]);
                    end else begin
                        passed++;
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs, advance the model, return 2ns after the edge.
    task automatic step(input logic fv, input logic [7:0] d, input logic fe, input logic rd,
                        input logic clr, input logic rs);
        bit rd_acc;
        bit wr_acc;
        bit full;
        rst = rs; frame_valid = fv; data_in = d; frame_error = fe;
        read_frame = rd; clear_overrun = clr;
        if (rs) begin
            model.delete();
            ovr_m  = 1'b0;
            last_m = '0;
        end else begin
            full   = (model.size() == 16);
            rd_acc = rd && (model.size() > 0);
            wr_acc = fv && (!full || rd_acc);
            if (rd_acc) begin
                last_m = model.pop_front();
                exp_q.push_back(last_m);
            end
            if (wr_acc) model.push_back({fe, d});
            if (fv && full && !rd_acc) ovr_m = 1'b1;
            else if (clr) ovr_m = 1'b0;
        end
        @(posedge clk);
        #2;
        rst = 1'b0; frame_valid = 1'b0; read_frame = 1'b0; clear_overrun = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && model.size() > 0; i++) step(0, 8'h00, 0, 1, 0, 0);
    endtask

    task automatic test_reset();
        step(0, 8'h00, 0, 0, 0, 1);
        mon_en = 1'b1;
        total++;
        if ({fifo_rx_count, fifo_rx_empty, fifo_rx_full, fifo_rx_afull, overrun} !== 9'b00000_1_0_0_0)
            $display("FAIL reset_flags: got count=%0d e=%b f=%b af=%b ovr=%b want 0 1 0 0 0",
                     fifo_rx_count, fifo_rx_empty, fifo_rx_full, fifo_rx_afull, overrun);
        else passed++;
        total++;
        if ({data_out_err, data_out, data_out_valid} !== 10'b0)
            $display("FAIL reset_out: got err=%b data=%h v=%b want 0 00 0",
                     data_out_err, data_out, data_out_valid);
        else passed++;
    endtask

    task automatic test_basic();
        step(1, 8'h41, 0, 0, 0, 0);
        step(1, 8'h42, 1, 0, 0, 0);
        step(1, 8'h43, 0, 0, 0, 0);
        total++;
        if (fifo_rx_count !== 5'd3) $display("FAIL basic_count: got %0d want 3", fifo_rx_count);
        else passed++;
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0);
        total++;
        if (fifo_rx_empty !== 1'b1 || fifo_rx_count !== 5'd0)
            $display("FAIL basic_empty: got e=%b count=%0d want 1 0", fifo_rx_empty, fifo_rx_count);
        else passed++;
    endtask

    task automatic test_fill();
        step(0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0, 0, 0);
            total++;
            if (fifo_rx_afull !== (i + 1 >= 12) || fifo_rx_full !== (i + 1 == 16)
                || fifo_rx_count !== 5'(i + 1))
                $display("FAIL fill_flags: got count=%0d af=%b f=%b want count=%0d af=%b f=%b",
                         fifo_rx_count, fifo_rx_afull, fifo_rx_full, i + 1, i + 1 >= 12,
                         i + 1 == 16);
            else passed++;
        end
        step(1, 8'hAA, 0, 0, 0, 0);
        total++;
        if (overrun !== 1'b1 || fifo_rx_count !== 5'd16)
            $display("FAIL fill_drop: got ovr=%b count=%0d want 1 16", overrun, fifo_rx_count);
        else passed++;
        drain();
        step(0, 8'h00, 0, 0, 1, 0);
    endtask

    task automatic test_full_rw();
        step(0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), i[0], 0, 0, 0);
        step(1, 8'h55, 0, 1, 0, 0);
        total++;
        if (fifo_rx_count !== 5'd16 || overrun !== 1'b0 || fifo_rx_full !== 1'b1)
            $display("FAIL full_rw: got count=%0d ovr=%b f=%b want 16 0 1",
                     fifo_rx_count, overrun, fifo_rx_full);
        else passed++;
        drain();
        total++;
        if (data_out !== 8'h55 || data_out !== last_m[7:0])
            $display("FAIL full_rw_last: got %h want 55", data_out);
        else passed++;
    endtask

    task automatic test_empty_read();
        step(0, 8'h00, 0, 0, 0, 1);
        step(1, 8'h3C, 1, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        total++;
        if (data_out_valid !== 1'b0 || data_out !== 8'h3C || data_out_err !== 1'b1)
            $display("FAIL empty_read_hold: got v=%b data=%h err=%b want 0 3c 1",
                     data_out_valid, data_out, data_out_err);
        else passed++;
        step(1, 8'h77, 0, 1, 0, 0);
        total++;
        if (fifo_rx_count !== 5'd1 || data_out_valid !== 1'b0 || fifo_rx_empty !== 1'b0)
            $display("FAIL empty_rw: got count=%0d v=%b e=%b want 1 0 0",
                     fifo_rx_count, data_out_valid, fifo_rx_empty);
        else passed++;
        drain();
    endtask

    task automatic test_overrun_clear();
        step(0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, 0);
        step(1, 8'hBB, 0, 0, 0, 0);
        step(1, 8'hBC, 0, 0, 1, 0);
        total++;
        if (overrun !== 1'b1 || overrun !== ovr_m)
            $display("FAIL ovr_clear_collide: got %b want 1", overrun);
        else passed++;
        step(0, 8'h00, 0, 0, 1, 0);
        total++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun);
        else passed++;
        drain();
    endtask

    task automatic test_reset_mid();
        step(0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
        step(1, 8'hEE, 0, 1, 0, 1);
        total++;
        if (fifo_rx_count !== 5'd0 || fifo_rx_empty !== 1'b1 || data_out_valid !== 1'b0)
            $display("FAIL mid_reset: got count=%0d e=%b v=%b want 0 1 0",
                     fifo_rx_count, fifo_rx_empty, data_out_valid);
        else passed++;
        step(1, 8'h99, 0, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        total++;
        if (data_out !== 8'h99 || fifo_rx_empty !== 1'b1)
            $display("FAIL mid_reset_pop: got data=%h e=%b want 99 1", data_out, fifo_rx_empty);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; frame_valid = 1'b0; data_in = '0; frame_error = 1'b0;
        read_frame = 1'b0; clear_overrun = 1'b0; ovr_m = 1'b0; last_m = '0;
        @(posedge clk);
        #2;
        test_reset();
        test_basic();
        test_fill();
        test_full_rw();
        test_empty_read();
        test_overrun_clear();
        test_reset_mid();
        step(0, 8'h00, 0, 0, 0, 0);
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
